// File: rtl/global_pkg.sv
// Shared types for the matrix-vector processor datapath.
package global_pkg;

   typedef logic [7:0] data_t;
   typedef logic [3:0] nibble_t;

endpackage : global_pkg

// File: rtl/uart_tx_pkg.sv
// Types and constants for the result transmit path: frame and serializer
// state encodings and the default frame delimiter bytes.
package uart_tx_pkg;

   import global_pkg::*;

   typedef enum logic [2:0] {
      IDLE,
      HEADER,
      LENGTH,
      DATA,
      TRAILER,
      FINISH
   } frame_state_t;

   typedef enum logic [1:0] {
      IDLE_B,
      START_B,
      DATA_B,
      STOP_B
   } byte_state_t;

   localparam data_t START_BYTE_DEF = 8'hFE;
   localparam data_t STOP_BYTE_DEF  = 8'hEF;

   // Bit index of the last data bit (index 0 is the start bit)
   localparam logic [3:0] LAST_DATA_BIT = 4'd8;

endpackage : uart_tx_pkg

// File: rtl/uart_tx_byte.sv
// 8N1 byte serializer. A byte_start pulse loads byte_in; from the next edge
// the line carries start bit, 8 data bits LSB first and a stop bit, each
// CLKS_PER_BIT clocks long. byte_done marks the last cycle of the stop bit.
module uart_tx_byte
   import uart_tx_pkg::*;
#(
   parameter int CLKS_PER_BIT = 434
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       byte_start,
   input  logic [7:0] byte_in,
   output logic       tx,
   output logic       byte_busy,
   output logic       byte_done
);

   localparam int BAUD_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
   localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);

   byte_state_t       state_reg;
   byte_state_t       state_next;
   logic [BAUD_W-1:0] baud_cnt_reg;
   logic [3:0]        bit_cnt_reg;
   logic [7:0]        shift_reg;
   logic              tx_reg;
   logic              bit_end;

   assign bit_end = (baud_cnt_reg == BAUD_LAST);
   assign tx      = tx_reg;

   // Serializer state register
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_reg <= IDLE_B;
      end else begin
         state_reg <= state_next;
      end
   end

   // Serializer next-state: advance at the end of each bit period
   always_comb begin
      state_next = state_reg;
      case (state_reg)
         IDLE_B:  if (byte_start) state_next = START_B;
         START_B: if (bit_end) state_next = DATA_B;
         DATA_B:  if (bit_end && (bit_cnt_reg == LAST_DATA_BIT)) state_next = STOP_B;
         STOP_B:  if (bit_end) state_next = IDLE_B;
         default: state_next = IDLE_B;
      endcase
   end

   // Serializer handshake outputs
   always_comb begin
      byte_busy = (state_reg != IDLE_B);
      byte_done = (state_reg == STOP_B) && bit_end;
   end

   // Baud counter, bit counter, shift register and registered line driver
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         baud_cnt_reg <= '0;
         bit_cnt_reg  <= '0;
         shift_reg    <= '0;
         tx_reg       <= 1'b1;
      end else if (state_reg == IDLE_B) begin
         baud_cnt_reg <= '0;
         bit_cnt_reg  <= '0;
         if (byte_start) begin
            shift_reg <= byte_in;
            tx_reg    <= 1'b0;
         end
      end else if (bit_end) begin
         baud_cnt_reg <= '0;
         bit_cnt_reg  <= (state_reg == STOP_B) ? 4'd0 : bit_cnt_reg + 4'd1;
         if ((state_next == STOP_B) || (state_next == IDLE_B)) begin
            tx_reg <= 1'b1;
         end else begin
            tx_reg    <= shift_reg[0];
            shift_reg <= {1'b0, shift_reg[7:1]};
         end
      end else begin
         baud_cnt_reg <= baud_cnt_reg + 1'b1;
      end
   end

endmodule : uart_tx_byte

// File: rtl/uart_result_tx.sv
// Result transmitter: on a transmit request, sends one framed packet
// (START_BYTE, length, N result bytes popped from the result FIFO, STOP_BYTE)
// over an 8N1 serial line. One idle cycle precedes the header and one gap
// cycle follows every byte, the last one before the FINISH/done cycle.
module uart_result_tx
   import global_pkg::*;
   import uart_tx_pkg::*;
#(
   parameter int          CLK_FREQ     = 50_000_000,
   parameter int          BAUD         = 115200,
   parameter int          CLKS_PER_BIT = CLK_FREQ / BAUD,
   parameter logic [7:0]  START_BYTE   = START_BYTE_DEF,
   parameter logic [7:0]  STOP_BYTE    = STOP_BYTE_DEF
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       transmit,
   input  logic [3:0] N,
   input  logic [7:0] data_in,
   output logic       pop,
   output logic       tx,
   output logic       busy,
   output logic       done
);

   frame_state_t state_reg;
   frame_state_t state_next;
   nibble_t      len_q;
   nibble_t      word_cnt;
   logic         sent_reg;    // current byte of this state already launched
   logic         prime_reg;   // one idle cycle between acceptance and header
   logic         byte_start;
   data_t        byte_data;
   logic         byte_busy;
   logic         byte_done;
   logic         send_state;

   assign send_state = (state_reg == HEADER) || (state_reg == LENGTH) ||
                       (state_reg == DATA)   || (state_reg == TRAILER);

   uart_tx_byte #(
      .CLKS_PER_BIT (CLKS_PER_BIT)
   ) u_byte (
      .clk        (clk),
      .rst        (rst),
      .byte_start (byte_start),
      .byte_in    (byte_data),
      .tx         (tx),
      .byte_busy  (byte_busy),
      .byte_done  (byte_done)
   );

   // Frame state register plus length latch, word counter and launch flags
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_reg <= IDLE;
         len_q     <= '0;
         word_cnt  <= '0;
         sent_reg  <= 1'b0;
         prime_reg <= 1'b0;
      end else begin
         state_reg <= state_next;
         prime_reg <= 1'b0;
         if ((state_reg == IDLE) && transmit) begin
            len_q     <= N;
            word_cnt  <= '0;
            sent_reg  <= 1'b0;
            prime_reg <= 1'b1;
         end else if (byte_start) begin
            sent_reg <= 1'b1;
            if (state_reg == DATA) word_cnt <= word_cnt + 4'd1;
         end else if (byte_done && (state_reg != TRAILER)) begin
            // The trailer keeps its flag so its gap cycle can be detected
            sent_reg <= 1'b0;
         end
      end
   end

   // Frame next-state: move on when the current byte's stop bit ends
   always_comb begin
      state_next = state_reg;
      case (state_reg)
         IDLE:    if (transmit) state_next = HEADER;
         HEADER:  if (byte_done) state_next = LENGTH;
         LENGTH:  if (byte_done) state_next = (len_q == 4'd0) ? TRAILER : DATA;
         DATA:    if (byte_done && (word_cnt == len_q)) state_next = TRAILER;
         TRAILER: if (sent_reg && !byte_busy) state_next = FINISH;
         FINISH:  state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   // Frame outputs: byte launch, byte source select, FIFO pop, status
   always_comb begin
      byte_start = send_state && !sent_reg && !prime_reg;
      byte_data  = 8'h00;
      case (state_reg)
         HEADER:  byte_data = START_BYTE;
         LENGTH:  byte_data = {4'b0000, len_q};
         DATA:    byte_data = data_in;
         TRAILER: byte_data = STOP_BYTE;
         default: byte_data = 8'h00;
      endcase
      pop  = byte_start && (state_reg == DATA);
      busy = (state_reg != IDLE) && (state_reg != FINISH);
      done = (state_reg == FINISH);
   end

endmodule : uart_result_tx

// File: doc/uart_result_tx.md
Name: uart_result_tx

Overview:
- Transmit end of the host UART link for the matrix-vector processor.
- On a `transmit` request, reads N result bytes from the result FIFO head (`result_uart_w`).
- Sends them to the host as one framed 8N1 serial packet: header, length, data, trailer.
- Mirrors the receive path that fills the A/B FIFOs. Sits between the processor top level and the FPGA TX pin.

Parameters:
- CLK_FREQ, 50_000_000: system clock frequency in Hz.
- BAUD, 115200: serial bit rate.
- CLKS_PER_BIT, CLK_FREQ/BAUD (434): clocks per serial bit. Overridable in simulation; must be ≥2.
- START_BYTE, 8'hFE: frame header byte.
- STOP_BYTE, 8'hEF: frame trailer byte.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous, active-low reset.
- transmit  in  1  frame request from the processor FSM; level or pulse.
- N  in  4  nibble_t, number of result bytes in the frame (0..15).
- data_in  in  8  data_t, result FIFO head; show-ahead, valid while FIFO is non-empty.
- pop  out  1  one-cycle pulse that advances the result FIFO.
- tx  out  1  serial line; idles high.
- busy  out  1  high while a frame is in progress.
- done  out  1  one-cycle pulse when a frame completes.

Behaviour:
- Reset values: tx=1, pop=0, busy=0, done=0. All counters and states clear immediately on rst low, including mid-frame; no pop is issued during reset.
- tx is driven from a flop (glitch-free).
- Frame FSM states: IDLE, HEADER, LENGTH, DATA, TRAILER, FINISH.
- IDLE:
  - On a clock edge with transmit=1, latch N into len_q and word_cnt=0, then go to HEADER.
  - busy rises on that edge.
  - transmit is ignored in every other state.
- HEADER: send START_BYTE, then go to LENGTH.
- LENGTH: send {4'b0, len_q}.
  - If len_q=0, go to TRAILER.
  - Otherwise go to DATA.
- DATA, per byte:
  - In the byte-load cycle, capture data_in into the serializer and assert pop for exactly that cycle.
  - Increment word_cnt.
  - After the byte's stop bit, repeat if word_cnt<len_q; else go to TRAILER.
- TRAILER: send STOP_BYTE, then go to FINISH.
- FINISH: lasts one cycle. done=1, busy drops to 0, return to IDLE. A new transmit is accepted from the next cycle.
- Byte serializer (8N1):
  - Load cycle: frame FSM issues byte_start with the byte value.
  - From the next edge: start bit 0, then 8 data bits LSB first, then stop bit 1.
  - Each bit lasts exactly CLKS_PER_BIT clocks.
  - The serializer issues byte_done in the last cycle of the stop bit.
- Inter-byte gap: the frame FSM issues the next byte_start in the cycle after byte_done. Each byte therefore occupies 10*CLKS_PER_BIT+1 clocks, with tx high in the gap cycle.
- Latency:
  - tx falls (header start bit) 2 edges after the edge that sampled transmit=1.
  - Whole frame, transmit-sample to done: (len_q+3)*(10*CLKS_PER_BIT+1)+2 clocks.
- N is sampled only on acceptance; later changes to N do not affect the current frame.
- FIFO underflow (empty while pops remain) is not detected. The block transmits whatever is on data_in, and the upstream FSM guarantees N valid entries.
- Bit counter: 4 bits (0..9). Baud counter: $clog2(CLKS_PER_BIT) bits, wraps to 0 at CLKS_PER_BIT-1.

Decomposition:
- Shared package `global_pkg` (existing) supplies data_t and nibble_t.
- New package `uart_tx_pkg` holds:
  - frame state enum;
  - START_BYTE and STOP_BYTE defaults;
  - serializer state enum: IDLE_B, START_B, DATA_B, STOP_B.
- One sub-module, `uart_tx_byte`.
  - Inputs: clk, rst, byte_start, byte_in.
  - Outputs: tx, byte_busy, byte_done.
  - Parameter: CLKS_PER_BIT.
  - It owns the baud counter, bit counter and shift register.
- uart_result_tx owns the frame FSM, word counter and pop generation.

Test Plan:
- Reset: hold rst=0 for 5 cycles with transmit=1 → tx=1, busy=0, pop=0, done=0 throughout.
- Two-byte frame: CLKS_PER_BIT=4, N=2, FIFO holds 0x35,0xA1, transmit pulse.
  - Bench UART monitor decodes FE 02 35 A1 EF.
  - Exactly 2 pop pulses, each in a DATA load cycle.
  - done pulses once, (2+3)*41+2=207 clocks after the accepting edge.
- Empty frame: N=0 → decoded FE 00 EF, zero pops, done after 3*41+2=125 clocks.
- Busy re-trigger: transmit held high through an N=1 frame (data 0x55).
  - First frame decodes FE 01 55 EF.
  - 0x55 bit order on tx is 0,1,0,1,0,1,0,1,0,1 (start, LSB first, stop).
  - A second frame starts only after done; no overlap.
- Reset mid-frame: assert rst during the 3rd data bit of data byte 1 (N=4).
  - tx=1 and busy=0 in the same cycle.
  - After release plus a transmit pulse, a full fresh frame starts with FE.
- Maximum frame: N=15 with data 0x00..0x0E → 18 bytes decoded in order, 15 pops, and N changed to 3 mid-frame has no effect.
